// File: rtl/nios_core_pkg.sv
// Shared definitions for the fabric-side helpers that sit beside the Nios core PIOs.
// Holds the poll FSM encoding and the key PIO register map.
package nios_core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } poll_state_t;

    localparam logic [1:0] KEY_PIO_DATA_ADDR = 2'd0;
    localparam int         PIO_READ_LATENCY  = 1;

endpackage

// File: rtl/nios_core_key_debounce.sv
// One-bit key debouncer: flips its state after DEBOUNCE_CNT consecutive differing samples.
// The flip pulse is combinational so the parent can build events on the same edge the state moves.
module nios_core_key_debounce #(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_en,
    input  logic raw,
    output logic state,
    output logic flip
);

    logic [3:0] cnt;
    logic       differs;

    assign differs = (raw != state);
    assign flip    = sample_en && differs && (cnt == 4'(DEBOUNCE_CNT - 1));

    // Any agreeing sample restarts the run, so a glitch shorter than the threshold leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            state <= 1'b0;
        end else if (sample_en) begin
            if (!differs || flip) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
            if (flip) begin
                state <= ~state;
            end
        end
    end

endmodule

// File: rtl/nios_core_key_poller.sv
// Avalon-MM read master that polls the key PIO at a fixed rate, debounces each key bit
// and presents press/release events to fabric logic through a valid/ready port.
module nios_core_key_poller
    import nios_core_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int POLL_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_waitrequest,
    output logic [WIDTH-1:0] key_state,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_mask,
    output logic [WIDTH-1:0] evt_state,
    output logic             evt_overflow,
    input  logic             ovf_clr
);

    localparam int                TICK_W      = $clog2(POLL_DIV);
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(POLL_DIV - 1);

    poll_state_t       state;
    poll_state_t       state_next;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              capture;
    logic [WIDTH-1:0]  raw;
    logic [WIDTH-1:0]  chg;
    logic [WIDTH-1:0]  new_key_state;
    logic              any_chg;
    logic              accept;
    logic              merge;
    logic              unused_readdata;

    assign tick = (tick_cnt == '0);

    // Free-running period counter; it never waits for the FSM, so a late poll is simply skipped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= TICK_RELOAD;
        end else if (tick) begin
            tick_cnt <= TICK_RELOAD;
        end else begin
            tick_cnt <= tick_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        avm_read   = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign avm_address = KEY_PIO_DATA_ADDR;

    // With a latency-1 slave the data is on the bus during the single WAIT cycle.
    assign capture         = (state == WAIT);
    assign raw             = avm_readdata[WIDTH-1:0] ^ {WIDTH{ACTIVE_LOW}};
    assign unused_readdata = ^avm_readdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        nios_core_key_debounce #(
            .DEBOUNCE_CNT(DEBOUNCE_CNT)
        ) u_debounce (
            .clk       (clk),
            .reset     (reset),
            .sample_en (capture),
            .raw       (raw[i]),
            .state     (key_state[i]),
            .flip      (chg[i])
        );
    end

    assign new_key_state = key_state ^ chg;
    assign any_chg       = |chg;
    assign accept        = evt_valid && evt_ready;
    assign merge         = any_chg && evt_valid && !evt_ready;

    // A change arriving while the previous event is still unaccepted is folded into it and flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_valid    <= 1'b0;
            evt_mask     <= '0;
            evt_state    <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (any_chg) begin
                evt_state <= new_key_state;
                if (merge) begin
                    evt_mask <= evt_mask | chg;
                end else begin
                    evt_mask  <= chg;
                    evt_valid <= 1'b1;
                end
            end else if (accept) begin
                evt_valid <= 1'b0;
            end

            if (merge) begin
                evt_overflow <= 1'b1;
            end else if (ovf_clr) begin
                evt_overflow <= 1'b0;
            end
        end
    end

endmodule
